// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//
// Sequencer in front of the M-extension divider wrapper. Accepts
// DIV/DIVU/REM/REMU ops from execute, settles divide-by-zero and signed
// overflow locally, otherwise launches the divider and holds its operands
// until it finishes. The result goes to writeback through a valid/ready
// handshake. A watchdog turns a stuck divider into an error result.
//
// Optional feature (macro DIV_ISSUE_CACHE_EN):
//   Defining DIV_ISSUE_CACHE_EN adds a one-entry result cache. It holds the
//   last op the divider computed, provided that op finished without error
//   and was not flushed. A repeated op returns the cached value with
//   single-cycle latency and does not launch the divider. Reset invalidates
//   the cache. flush does not.
//   If the macro is undefined, every non-special op goes to the divider.
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 48,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            flush,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_func3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_tag,

  output logic            div_go,
  output logic            div_clr,
  output logic [1:0]      div_func3,
  output logic [XLEN-1:0] div_rs1,
  output logic [XLEN-1:0] div_rs2,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_rd,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_tag,
  output logic            out_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  // The watchdog counts WAIT cycles. The timeout fires on the last permitted one.
  localparam int                WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [WD_W-1:0] watchdog;

  // Decode of the op currently offered by execute.
  logic            is_rem;
  logic            is_unsigned;
  logic            div_by_zero;
  logic            sgn_overflow;
  logic            is_special;
  logic [XLEN-1:0] special_result;
  logic            cache_hit;
  logic            fast_path;
  logic [XLEN-1:0] fast_result;

`ifdef DIV_ISSUE_CACHE_EN
  logic            cache_valid;
  logic [1:0]      cache_func3;
  logic [XLEN-1:0] cache_rs1;
  logic [XLEN-1:0] cache_rs2;
  logic [XLEN-1:0] cache_result;

  assign cache_hit = cache_valid
                   && (cache_func3 == in_func3)
                   && (cache_rs1   == in_rs1)
                   && (cache_rs2   == in_rs2);

  // Valid bit: cleared by reset only, set when the divider completes an op in WAIT.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cache_valid <= 1'b0;
    end else if ((state == WAIT) && div_done && !flush) begin
      cache_valid <= 1'b1;
    end
  end

  // Payload: captured alongside the valid bit. It is never read unless cache_valid is set.
  // NOTE: payload registers have no reset; the valid bit alone gates their use,
  // so resetting them would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if ((state == WAIT) && div_done && !flush) begin
      cache_func3  <= div_func3;
      cache_rs1    <= div_rs1;
      cache_rs2    <= div_rs2;
      cache_result <= div_rd;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Classify the offered op and pick the locally produced result.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    is_rem         = in_func3[1];
    is_unsigned    = in_func3[0];
    div_by_zero    = (in_rs2 == '0);
    sgn_overflow   = !is_unsigned && (in_rs1 == MIN_NEG) && (in_rs2 == ALL_ONES);
    is_special     = div_by_zero || sgn_overflow;
    special_result = '0;
    if (div_by_zero) begin
      special_result = is_rem ? in_rs1 : ALL_ONES;
    end else if (sgn_overflow) begin
      special_result = is_rem ? '0 : MIN_NEG;
    end
    fast_path   = is_special || cache_hit;
    fast_result = special_result;
`ifdef DIV_ISSUE_CACHE_EN
    if (!is_special) begin
      fast_result = cache_result;
    end
`endif
  end

  // Sequencer FSM: accept, launch, wait with watchdog, and hold the result until drained.
  // NOTE: state and outputs use non-blocking assignments, so every decision
  // in this block sees the values the registers held before the edge.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      div_go     <= 1'b0;
      div_clr    <= 1'b1;
      div_func3  <= '0;
      div_rs1    <= '0;
      div_rs2    <= '0;
      watchdog   <= '0;
    end else begin
      div_go  <= 1'b0;
      div_clr <= 1'b0;
      if (flush) begin
        // Kill wins over any accept or drain in the same cycle.
        state     <= IDLE;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        out_err   <= 1'b0;
        watchdog  <= '0;
        div_clr   <= (state == LAUNCH) || (state == WAIT);
      end else begin
        unique case (state)
          IDLE: begin
            if (in_valid && in_ready) begin
              in_ready  <= 1'b0;
              div_func3 <= in_func3;
              div_rs1   <= in_rs1;
              div_rs2   <= in_rs2;
              out_tag   <= in_tag;
              watchdog  <= '0;
              if (fast_path) begin
                state      <= HOLD;
                out_valid  <= 1'b1;
                out_result <= fast_result;
                out_err    <= 1'b0;
              end else begin
                state  <= LAUNCH;
                div_go <= 1'b1;
              end
            end
          end

          LAUNCH: begin
            state <= WAIT;
          end

          WAIT: begin
            if (div_done) begin
              state      <= HOLD;
              out_valid  <= 1'b1;
              out_result <= div_rd;
              out_err    <= 1'b0;
              watchdog   <= '0;
            end else if (watchdog == WD_LAST) begin
              state      <= HOLD;
              out_valid  <= 1'b1;
              out_result <= ALL_ONES;
              out_err    <= 1'b1;
              div_clr    <= 1'b1;
              watchdog   <= '0;
            end else begin
              watchdog <= watchdog + 1'b1;
            end
          end

          HOLD: begin
            if (out_ready) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_err   <= 1'b0;
            end
          end

          default: begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequencer directly upstream of the M-extension divider wrapper.
- Accepts DIV/DIVU/REM/REMU ops from execute via valid/ready.
- Resolves RISC-V divide-by-zero and signed-overflow cases locally, without invoking the divider.
- Otherwise launches the divider, holds its operands stable until done, and presents the result to writeback via valid/ready, with a watchdog timeout.

Parameters:
- TIMEOUT_CYCLES, 48: max cycles from div_go to div_done before the timeout error fires.
- XLEN, 32: operand/result width; only 32 is supported.

Ports:
- clk  input  1  clock
- clr_n  input  1  synchronous active-low reset
- flush  input  1  pipeline kill; abandons any op in flight
- in_valid  input  1  op request from execute
- in_ready  output  1  controller can accept an op
- in_func3  input  2  {is_rem, is_unsigned}: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- in_rs1  input  32  dividend
- in_rs2  input  32  divisor
- in_tag  input  5  destination register index
- div_go  output  1  one-cycle start pulse to divider wrapper
- div_clr  output  1  one-cycle clear to divider wrapper
- div_func3  output  2  func3 to divider wrapper
- div_rs1  output  32  dividend to divider wrapper
- div_rs2  output  32  divisor to divider wrapper
- div_done  input  1  wrapper done; div_rd is valid in the same cycle
- div_rd  input  32  wrapper result
- out_valid  output  1  result available to writeback
- out_ready  input  1  writeback accepts the result
- out_result  output  32  final rd value
- out_tag  output  5  destination index
- out_err  output  1  result was produced by timeout; qualified by out_valid

Behaviour:
- Reset (clr_n=0 at posedge):
  - state=IDLE.
  - in_ready=1; out_valid=0; out_result=0; out_tag=0; out_err=0.
  - div_go=0; div_clr=1 for that cycle; div_rs1/div_rs2/div_func3=0; watchdog=0.
- States: IDLE, LAUNCH, WAIT, HOLD. in_ready=1 only in IDLE.
- Accept: in_valid & in_ready at edge N. Latch func3/rs1/rs2/tag into the div_* and tag registers.
- Special cases, decided at accept; state goes directly to HOLD, out_valid=1 at N+1:
  - rs2==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - Signed ops with rs1==0x80000000 and rs2==0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
  - Divide-by-zero has priority over overflow.
- Normal path:
  - state=LAUNCH at N+1 with div_go=1 for exactly one cycle.
  - Then WAIT; watchdog increments each cycle in WAIT.
- WAIT:
  - On div_done: capture div_rd into out_result, out_err=0, state=HOLD; out_valid=1 the following cycle.
  - If watchdog reaches TIMEOUT_CYCLES before div_done: out_result=0xFFFFFFFF, out_err=1, div_clr pulse, state=HOLD.
- Operand stability: div_rs1/div_rs2/div_func3 must not change from accept until leaving WAIT. The wrapper re-reads operand signs every cycle to sign-correct its result.
- HOLD: out_valid, out_result and out_tag held stable until out_ready=1. out_valid & out_ready -> IDLE; in_ready=1 on the next cycle. No accept in the same cycle as drain.
- div_done outside WAIT is ignored.
- flush (any state): state=IDLE next cycle, out_valid=0, out_err=0, watchdog=0. If flushed in LAUNCH or WAIT, div_clr=1 for one cycle. flush overrides a same-cycle accept and drain.
- Reset mid-operation: identical to reset values; divider is cleared via div_clr.

Optional Feature:
- Macro: DIV_ISSUE_CACHE_EN.
- When defined:
  - Store {func3, rs1, rs2, result} of the last divider-computed, non-error, non-flushed op, plus a valid bit.
  - An accepted op matching all three fields goes directly to HOLD with the cached result (1-cycle latency, no div_go).
  - flush does not invalidate the cache; reset does.
- When undefined: no cache storage; every non-special op launches the divider.

Test Plan:
- DIV rs1=100, rs2=7, divider model done after 34 cycles with rd=14 -> div_go single pulse at N+1; out_valid the cycle after done; out_result=14, out_tag echoed, out_err=0.
- DIVU rs1=5, rs2=0 -> no div_go; out_result=0xFFFFFFFF at N+1. REMU same operands -> out_result=5.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> out_result=0x80000000. REM same operands -> 0. No div_go in either case.
- Divider model never asserts done -> after 48 WAIT cycles: div_clr pulse, out_valid=1, out_err=1, out_result=0xFFFFFFFF.
- out_ready held low for 10 cycles in HOLD -> out_* stable and in_ready=0 throughout. flush asserted mid-WAIT -> div_clr pulse, IDLE next cycle, a late div_done is ignored.
- With DIV_ISSUE_CACHE_EN: REM 100,7 computed (rd=2), then REM 100,7 again -> second op gives out_valid at N+1 with 2 and no div_go. Then REM 100,8 -> divider launched.
